memory_access: RTL and testbench

Pipeline stage downstream of the execution stage: consumes its one-cycle `valid` pulse with ALU result, store data and control bits, and performs the data-memory read/write or UART receive. Presents a single-pulse writeback bundle to the register file. Multi-cycle operations stall upstream through `busy`. Sits between execution and writeback, driving the synchronous data RAM and the UART RX handshake.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/wb_sel.sv | 34 +++
 rtl/memory_access.sv | 207 ++++++++++++++++++++
 tb/tb_memory_access.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory-access pipeline stage.
//   mem_state_t   - memory-stage FSM states.
//   WB_SEL_*      - MemtoReg writeback-select encodings (2'b11 is reserved and behaves as
//                   WB_SEL_RESULT).
package mem_stage_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStore,
        StLoadAddr,
        StLoadData,
        StUartWait
    } mem_state_t;

    localparam logic [1:0] WB_SEL_RESULT = 2'b00;
    localparam logic [1:0] WB_SEL_MEM    = 2'b01;
    localparam logic [1:0] WB_SEL_LINK   = 2'b10;

endpackage

// File: rtl/wb_sel.sv
// wb_sel: combinational 32-bit writeback mux.
//   sel       in  2   MemtoReg-style select (result / memory / link; reserved -> result)
//   uart_sel  in  1   overrides sel and picks the UART operand
//   result    in  32  ALU/FPU result
//   mem_rdata in  32  data RAM read data
//   link      in  32  zero-extended link value
//   uart      in  32  zero-extended UART byte
//   data      out 32  selected writeback value
module wb_sel
    import mem_stage_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic        uart_sel,
    input  logic [31:0] result,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] link,
    input  logic [31:0] uart,
    output logic [31:0] data
);

    always_comb begin
        data = result;
        if (uart_sel) begin
            data = uart;
        end else begin
            case (sel)
                WB_SEL_MEM:  data = mem_rdata;
                WB_SEL_LINK: data = link;
                default:     data = result;
            endcase
        end
    end

endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline stage between execute and writeback. Accepts a one-cycle valid_in
// pulse, performs a data-RAM store/load or UART receive, and emits a one-cycle writeback pulse.
// Optional feature macro: MEMORY_ACCESS_UART_EN (enables the UART_WAIT receive path; when
// undefined, UARTtoReg ops complete in one cycle with wb_data = 0 and uart_rx_ready tied 0).
// Ports:
//   CLK, reset                      clock, asynchronous active-high reset
//   valid_in, RegWrite, MemWrite,   operation pulse and control from execute
//   MemRead, UARTtoReg, MemtoReg
//   result, register_data, rdist,   ALU result (low bits = word address), store data,
//   pc1                             destination register, link value
//   mem_addr, mem_wdata, mem_we,    synchronous data RAM port (read data one cycle later)
//   mem_rdata
//   uart_rx_data, uart_rx_valid,    UART receive handshake
//   uart_rx_ready
//   wb_valid, wb_RegWrite,          writeback bundle (wb_valid is a single pulse)
//   wb_rdist, wb_data
//   busy, overrun                   stall to upstream, sticky "valid_in while busy" flag
module memory_access
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_MEM_WIDTH = 10,
    parameter int unsigned INST_MEM_WIDTH = 2
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic                      RegWrite,
    input  logic                      MemWrite,
    input  logic                      MemRead,
    input  logic                      UARTtoReg,
    input  logic [1:0]                MemtoReg,
    input  logic [31:0]               result,
    input  logic [31:0]               register_data,
    input  logic [4:0]                rdist,
    input  logic [INST_MEM_WIDTH-1:0] pc1,
    output logic [DATA_MEM_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      mem_we,
    input  logic [31:0]               mem_rdata,
    input  logic [7:0]                uart_rx_data,
    input  logic                      uart_rx_valid,
    output logic                      uart_rx_ready,
    output logic                      wb_valid,
    output logic                      wb_RegWrite,
    output logic [4:0]                wb_rdist,
    output logic [31:0]               wb_data,
    output logic                      busy,
    output logic                      overrun
);

    mem_state_t  state_q;
    logic [31:0] result_q;
    logic [1:0]  memtoreg_q;
    logic        regwrite_q;
    logic [4:0]  rdist_q;

    logic [1:0]  mux_sel;
    logic        mux_uart;
    logic [31:0] mux_result;
    logic        mux_regwrite;
    logic [4:0]  mux_rdist;
    logic [31:0] mux_data;
    logic [31:0] link;
    logic [31:0] uart_word;

    assign link = {{(32 - INST_MEM_WIDTH){1'b0}}, pc1};
    assign busy = (state_q != StIdle);

`ifdef MEMORY_ACCESS_UART_EN
    logic rx_ready_q;
    assign uart_word     = {24'b0, uart_rx_data};
    assign uart_rx_ready = rx_ready_q;
`else
    logic unused_uart;
    assign unused_uart   = ^{uart_rx_data, uart_rx_valid};
    assign uart_word     = 32'b0;
    assign uart_rx_ready = 1'b0;
`endif

    // In IDLE the writeback bundle comes straight from the inputs (single-cycle ops);
    // in every other state it comes from the values latched at accept.
    always_comb begin
        mux_sel      = WB_SEL_RESULT;
        mux_uart     = 1'b0;
        mux_result   = result_q;
        mux_regwrite = regwrite_q;
        mux_rdist    = rdist_q;
        case (state_q)
            StIdle: begin
                mux_result   = result;
                mux_regwrite = RegWrite;
                mux_rdist    = rdist;
                mux_uart     = UARTtoReg;
                mux_sel      = (MemtoReg == WB_SEL_LINK) ? WB_SEL_LINK : WB_SEL_RESULT;
            end
            StLoadData: begin
                mux_sel = (memtoreg_q == WB_SEL_MEM) ? WB_SEL_MEM : WB_SEL_RESULT;
            end
            StUartWait: begin
                mux_uart = 1'b1;
            end
            default: begin
                mux_sel = WB_SEL_RESULT;
            end
        endcase
    end

    wb_sel u_wb_sel (
        .sel       (mux_sel),
        .uart_sel  (mux_uart),
        .result    (mux_result),
        .mem_rdata (mem_rdata),
        .link      (link),
        .uart      (uart_word),
        .data      (mux_data)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            result_q    <= 32'b0;
            memtoreg_q  <= 2'b0;
            regwrite_q  <= 1'b0;
            rdist_q     <= 5'b0;
            mem_addr    <= '0;
            mem_wdata   <= 32'b0;
            mem_we      <= 1'b0;
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_rdist    <= 5'b0;
            wb_data     <= 32'b0;
            overrun     <= 1'b0;
`ifdef MEMORY_ACCESS_UART_EN
            rx_ready_q  <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            mem_we   <= 1'b0;

            if (valid_in && (state_q != StIdle)) begin
                overrun <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        result_q   <= result;
                        memtoreg_q <= MemtoReg;
                        regwrite_q <= RegWrite;
                        rdist_q    <= rdist;
                        if (UARTtoReg) begin
`ifdef MEMORY_ACCESS_UART_EN
                            state_q    <= StUartWait;
                            rx_ready_q <= 1'b1;
`else
                            wb_valid    <= 1'b1;
                            wb_RegWrite <= mux_regwrite;
                            wb_rdist    <= mux_rdist;
                            wb_data     <= mux_data;
`endif
                        end else if (MemWrite) begin
                            state_q   <= StStore;
                            mem_addr  <= result[DATA_MEM_WIDTH-1:0];
                            mem_wdata <= register_data;
                            mem_we    <= 1'b1;
                        end else if (MemRead) begin
                            state_q  <= StLoadAddr;
                            mem_addr <= result[DATA_MEM_WIDTH-1:0];
                        end else begin
                            wb_valid    <= 1'b1;
                            wb_RegWrite <= mux_regwrite;
                            wb_rdist    <= mux_rdist;
                            wb_data     <= mux_data;
                        end
                    end
                end
                StStore, StLoadData: begin
                    state_q     <= StIdle;
                    wb_valid    <= 1'b1;
                    wb_RegWrite <= mux_regwrite;
                    wb_rdist    <= mux_rdist;
                    wb_data     <= mux_data;
                end
                StLoadAddr: begin
                    state_q <= StLoadData;
                end
`ifdef MEMORY_ACCESS_UART_EN
                StUartWait: begin
                    // ready is held high throughout this state, so valid alone completes it
                    if (uart_rx_valid) begin
                        state_q     <= StIdle;
                        rx_ready_q  <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_RegWrite <= mux_regwrite;
                        wb_rdist    <= mux_rdist;
                        wb_data     <= mux_data;
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized scoreboard bench for memory_access. A driver issues operations
// and pushes the expected writeback (and expected RAM write) into queues; a monitor compares
// them whenever the DUT presents wb_valid / mem_we. Honours MEMORY_ACCESS_UART_EN.
module tb_memory_access;

    localparam int DW = 10;
    localparam int IW = 2;
    localparam int NEVER = 32'h7fff_ffff;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rdist;
        logic        rw;
        int          cycle;
    } wb_exp_t;

    typedef struct {
        logic [DW-1:0] addr;
        logic [31:0]   data;
        int            cycle;
    } st_exp_t;

    logic          CLK = 1'b0;
    logic          reset;
    logic          valid_in, RegWrite, MemWrite, MemRead, UARTtoReg;
    logic [1:0]    MemtoReg;
    logic [31:0]   result, register_data;
    logic [4:0]    rdist;
    logic [IW-1:0] pc1;
    logic [DW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic [7:0]    uart_rx_data;
    logic          uart_rx_valid, uart_rx_ready;
    logic          wb_valid, wb_RegWrite;
    logic [4:0]    wb_rdist;
    logic [31:0]   wb_data;
    logic          busy, overrun;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    logic          exp_overrun = 1'b0;
    logic          ram_clr;
    logic [31:0]   ram  [0:(1<<DW)-1];
    logic [31:0]   gold [0:(1<<DW)-1];
    wb_exp_t       wbq[$];
    st_exp_t       sq[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    memory_access #(
        .DATA_MEM_WIDTH (DW),
        .INST_MEM_WIDTH (IW)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .valid_in      (valid_in),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .MemRead       (MemRead),
        .UARTtoReg     (UARTtoReg),
        .MemtoReg      (MemtoReg),
        .result        (result),
        .register_data (register_data),
        .rdist         (rdist),
        .pc1           (pc1),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .wb_valid      (wb_valid),
        .wb_RegWrite   (wb_RegWrite),
        .wb_rdist      (wb_rdist),
        .wb_data       (wb_data),
        .busy          (busy),
        .overrun       (overrun)
    );

    // Synchronous data RAM: read data appears one cycle after the address.
    always @(posedge CLK) begin
        if (ram_clr) begin
            for (int i = 0; i < (1 << DW); i++) ram[i] <= 32'b0;
            mem_rdata <= 32'b0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues away from the active edge.
    initial begin
        wb_exp_t e;
        st_exp_t s;
        logic    exp_busy;
        forever begin
            @(negedge CLK);
            if (!reset) begin
                exp_busy = (wbq.size() > 0) && (cyc < wbq[0].cycle);
                chk("busy", {31'b0, busy}, {31'b0, exp_busy});
                chk("overrun", {31'b0, overrun}, {31'b0, exp_overrun});
`ifndef MEMORY_ACCESS_UART_EN
                chk("rx_ready_tied", {31'b0, uart_rx_ready}, 32'b0);
`endif
                if (wb_valid) begin
                    if (wbq.size() == 0) begin
                        chk("wb_unexpected", 32'b1, 32'b0);
                    end else begin
                        e = wbq.pop_front();
                        chk("wb_data", wb_data, e.data);
                        chk("wb_rdist", {27'b0, wb_rdist}, {27'b0, e.rdist});
                        chk("wb_RegWrite", {31'b0, wb_RegWrite}, {31'b0, e.rw});
                        chk("wb_cycle", cyc, e.cycle);
                    end
                end else if (wbq.size() > 0 && cyc > wbq[0].cycle) begin
                    e = wbq.pop_front();
                    chk("wb_missing", 32'b0, 32'b1);
                end
                if (mem_we) begin
                    if (sq.size() == 0) begin
                        chk("mem_we_unexpected", 32'b1, 32'b0);
                    end else begin
                        s = sq.pop_front();
                        chk("mem_addr", {22'b0, mem_addr}, {22'b0, s.addr});
                        chk("mem_wdata", mem_wdata, s.data);
                        chk("mem_we_cycle", cyc, s.cycle);
                    end
                end else if (sq.size() > 0 && cyc > sq[0].cycle) begin
                    s = sq.pop_front();
                    chk("mem_we_missing", 32'b0, 32'b1);
                end
            end
        end
    end

    // Issue one operation; udelay < 0 on a UART op means no byte is ever supplied.
    task automatic issue(input logic u, input logic mw, input logic mr, input logic rw,
                         input logic [1:0] m2r, input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input logic [IW-1:0] pc, input int udelay,
                         input logic [7:0] ub);
        int            c;
        int            n;
        wb_exp_t       e;
        st_exp_t       s;
        logic          do_store;
        logic [DW-1:0] addr;
        @(negedge CLK);
        n = 0;
        while (busy && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (busy) chk("idle_wait", {31'b0, busy}, 32'b0);
        valid_in = 1'b1;  UARTtoReg = u;  MemWrite = mw;  MemRead = mr;  RegWrite = rw;
        MemtoReg = m2r;   result = res;   register_data = sd;  rdist = rd;  pc1 = pc;
        c        = cyc;
        addr     = res[DW-1:0];
        do_store = 1'b0;
        e.rdist  = rd;
        e.rw     = rw;
        if (u) begin
`ifdef MEMORY_ACCESS_UART_EN
            e.data  = {24'b0, ub};
            e.cycle = (udelay < 0) ? NEVER : c + 2 + udelay;
`else
            e.data  = 32'b0;
            e.cycle = c + 1;
`endif
        end else if (mw) begin
            gold[addr] = sd;
            e.data     = res;
            e.cycle    = c + 2;
            do_store   = 1'b1;
            s.addr     = addr;
            s.data     = sd;
            s.cycle    = c + 1;
        end else if (mr) begin
            e.data  = (m2r == 2'b01) ? gold[addr] : res;
            e.cycle = c + 3;
        end else begin
            e.data  = (m2r == 2'b10) ? {30'b0, pc} : res;
            e.cycle = c + 1;
        end
        @(posedge CLK);
        #1;
        valid_in = 1'b0;
        wbq.push_back(e);
        if (do_store) sq.push_back(s);
`ifdef MEMORY_ACCESS_UART_EN
        if (u && udelay >= 0) begin
            repeat (udelay + 1) @(negedge CLK);
            chk("rx_ready", {31'b0, uart_rx_ready}, 32'b1);
            uart_rx_valid = 1'b1;
            uart_rx_data  = ub;
            @(posedge CLK);
            #1;
            uart_rx_valid = 1'b0;
        end
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'b0);
        chk({tag, "_wb_data"}, wb_data, 32'b0);
        chk({tag, "_wb_rdist"}, {27'b0, wb_rdist}, 32'b0);
        chk({tag, "_wb_RegWrite"}, {31'b0, wb_RegWrite}, 32'b0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'b0);
        chk({tag, "_overrun"}, {31'b0, overrun}, 32'b0);
        chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'b0);
        chk({tag, "_rx_ready"}, {31'b0, uart_rx_ready}, 32'b0);
    endtask

    initial begin
        int            n;
        int            kind;
        logic [31:0]   res;
        logic [DW-1:0] a;
        valid_in = 0;  RegWrite = 0;  MemWrite = 0;  MemRead = 0;  UARTtoReg = 0;
        MemtoReg = 0;  result = 0;  register_data = 0;  rdist = 0;  pc1 = 0;
        uart_rx_data = 0;  uart_rx_valid = 0;
        reset   = 1'b1;
        ram_clr = 1'b1;
        for (int i = 0; i < (1 << DW); i++) gold[i] = 32'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        chk("reset_mem_addr", {22'b0, mem_addr}, 32'b0);
        chk("reset_mem_wdata", mem_wdata, 32'b0);
        ram_clr = 1'b0;
        reset   = 1'b0;

        // Directed cases
        issue(0, 0, 0, 1, 2'b00, 32'h0000_002A, 32'h0, 5'd3, 2'd0, 0, 8'h0);
        issue(0, 1, 0, 1, 2'b00, 32'h0000_0005, 32'hDEAD_BEEF, 5'd7, 2'd1, 0, 8'h0);
        issue(0, 0, 1, 1, 2'b01, 32'h0000_0005, 32'h0, 5'd9, 2'd2, 0, 8'h0);
        issue(0, 0, 0, 1, 2'b10, 32'h0000_1234, 32'h0, 5'd4, 2'd3, 0, 8'h0);
        issue(0, 0, 0, 0, 2'b11, 32'h0BAD_F00D, 32'h0, 5'd5, 2'd3, 0, 8'h0);
        issue(0, 1, 1, 1, 2'b01, 32'hFFFF_FC06, 32'h1357_9BDF, 5'd6, 2'd0, 0, 8'h0);
        issue(0, 0, 1, 1, 2'b10, 32'h0000_0006, 32'h0, 5'd8, 2'd1, 0, 8'h0);
        issue(0, 0, 1, 1, 2'b01, 32'h0000_0006, 32'h0, 5'd8, 2'd1, 0, 8'h0);
        issue(1, 0, 0, 1, 2'b00, 32'h0000_0099, 32'h0, 5'd12, 2'd0, 4, 8'h41);
        issue(1, 1, 0, 1, 2'b00, 32'h0000_0007, 32'hAAAA_5555, 5'd13, 2'd0, 0, 8'hC3);

        // Overrun: second valid_in during a load is dropped, the load still completes
        issue(0, 0, 1, 1, 2'b01, 32'h0000_0005, 32'h0, 5'd10, 2'd0, 0, 8'h0);
        @(negedge CLK);
        valid_in = 1'b1;  UARTtoReg = 0;  MemWrite = 1;  MemRead = 0;
        result = 32'h0000_0005;  register_data = 32'h0;  rdist = 5'd31;
        @(posedge CLK);
        #1;
        valid_in    = 1'b0;
        MemWrite    = 1'b0;
        exp_overrun = 1'b1;
        issue(0, 0, 0, 1, 2'b00, 32'h0000_0077, 32'h0, 5'd11, 2'd0, 0, 8'h0);

        // Asynchronous reset mid-operation
`ifdef MEMORY_ACCESS_UART_EN
        issue(1, 0, 0, 1, 2'b00, 32'h0, 32'h0, 5'd14, 2'd0, -1, 8'h0);
        repeat (3) @(negedge CLK);
        chk("pre_reset_rx_ready", {31'b0, uart_rx_ready}, 32'b1);
        @(posedge CLK);
`else
        issue(0, 0, 1, 1, 2'b01, 32'h0000_0005, 32'h0, 5'd14, 2'd0, 0, 8'h0);
`endif
        #2;
        chk("pre_reset_busy", {31'b0, busy}, 32'b1);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        wbq.delete();
        sq.delete();
        exp_overrun = 1'b0;
        reset = 1'b0;
        issue(0, 0, 0, 1, 2'b00, 32'h0000_00A5, 32'h0, 5'd15, 2'd0, 0, 8'h0);

        // Randomized traffic over a small address window so loads hit earlier stores
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 3);
            a    = DW'($urandom_range(0, 15));
            res  = $urandom();
            res[DW-1:0] = a;
            issue(kind == 3, (kind == 1) || ((kind == 3) && ($urandom_range(0, 1) == 1)),
                  (kind == 2) || ($urandom_range(0, 3) == 0), 1'($urandom()),
                  2'($urandom()), res, $urandom(), 5'($urandom()), 2'($urandom()),
                  $urandom_range(0, 5), 8'($urandom()));
        end

        n = 0;
        while ((wbq.size() > 0 || sq.size() > 0) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("drain", wbq.size() + sq.size(), 32'b0);
        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

endmodule
